// File: rtl/router_multi_vnet.sv
// Mesh NoC router: per-channel input FIFOs, XY routing, and a round-robin wormhole
// arbiter per (output port, vnet). Channel index c = port*VNET_NUMBER + vnet.
module router_multi_vnet #(
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 4,
    parameter int PORT_NUMBER   = 5,
    parameter int VNET_NUMBER   = 2,
    parameter int BUFFER_LENGTH = 16,
    parameter int MAX_ROUTERS_X = 4,
    parameter int MAX_ROUTERS_Y = 4,
    parameter int ROUTER_X      = 0,
    parameter int ROUTER_Y      = 0,
    localparam int CHANNEL_NUMBER = PORT_NUMBER * VNET_NUMBER,
    localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_tdata  [CHANNEL_NUMBER],
    input  logic [STRB_WIDTH-1:0] in_tstrb  [CHANNEL_NUMBER],
    input  logic [ID_WIDTH-1:0]   in_tid    [CHANNEL_NUMBER],
    input  logic                  in_tlast  [CHANNEL_NUMBER],
    input  logic                  in_tvalid [CHANNEL_NUMBER],
    output logic                  in_tready [CHANNEL_NUMBER],
    output logic [DATA_WIDTH-1:0] out_tdata  [CHANNEL_NUMBER],
    output logic [STRB_WIDTH-1:0] out_tstrb  [CHANNEL_NUMBER],
    output logic [ID_WIDTH-1:0]   out_tid    [CHANNEL_NUMBER],
    output logic                  out_tlast  [CHANNEL_NUMBER],
    output logic                  out_tvalid [CHANNEL_NUMBER],
    input  logic                  out_tready [CHANNEL_NUMBER]
);
    localparam int FW = DATA_WIDTH + STRB_WIDTH + ID_WIDTH + 1;
    localparam int AW = $clog2(BUFFER_LENGTH);
    localparam int PW = (PORT_NUMBER > 1) ? $clog2(PORT_NUMBER) : 1;
    localparam int XW = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1;
    localparam int YW = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(BUFFER_LENGTH);

    function automatic logic [PW-1:0] route_of(input logic [XW+YW-1:0] dest);
        int dx;
        int dy;
        dx = int'(dest[XW-1:0]);
        dy = int'(dest[XW +: YW]);
        if (dx > ROUTER_X) return PW'(2);
        if (dx < ROUTER_X) return PW'(4);
        if (dy > ROUTER_Y) return PW'(3);
        if (dy < ROUTER_Y) return PW'(1);
        return PW'(0);
    endfunction

    logic [FW-1:0] mem [CHANNEL_NUMBER][BUFFER_LENGTH];
    logic [AW-1:0] wr_ptr    [CHANNEL_NUMBER];
    logic [AW-1:0] rd_ptr    [CHANNEL_NUMBER];
    logic [AW:0]   count     [CHANNEL_NUMBER];
    logic [FW-1:0] head      [CHANNEL_NUMBER];
    logic          head_vld  [CHANNEL_NUMBER];
    logic          push      [CHANNEL_NUMBER];
    logic          pop       [CHANNEL_NUMBER];
    logic [PW-1:0] route     [CHANNEL_NUMBER];
    logic [PW-1:0] route_lat [CHANNEL_NUMBER];
    logic          route_vld [CHANNEL_NUMBER];
    // Arbiter state below is indexed by output channel.
    logic          locked    [CHANNEL_NUMBER];
    logic [PW-1:0] owner     [CHANNEL_NUMBER];
    logic [PW-1:0] rr_ptr    [CHANNEL_NUMBER];
    logic [PW-1:0] sel       [CHANNEL_NUMBER];
    logic          sel_vld   [CHANNEL_NUMBER];
    logic          done      [CHANNEL_NUMBER];

    // Input side: FIFO head, ready and route (latched once the head flit has left).
    always_comb begin
        for (int c = 0; c < CHANNEL_NUMBER; c++) begin
            head_vld[c]  = (count[c] != '0);
            head[c]      = mem[c][rd_ptr[c]];
            in_tready[c] = !rst && (count[c] != FULL_CNT);
            push[c]      = in_tready[c] && in_tvalid[c];
            route[c]     = route_vld[c] ? route_lat[c] : route_of(head[c][XW+YW-1:0]);
        end
    end

    // Output side: a locked arbiter mirrors its owner's FIFO head.
    always_comb begin
        int qc;
        for (int c = 0; c < CHANNEL_NUMBER; c++) pop[c] = 1'b0;
        for (int oc = 0; oc < CHANNEL_NUMBER; oc++) begin
            qc = int'(owner[oc]) * VNET_NUMBER + oc % VNET_NUMBER;
            out_tvalid[oc] = !rst && locked[oc] && head_vld[qc];
            out_tdata[oc]  = out_tvalid[oc] ? head[qc][DATA_WIDTH-1:0] : '0;
            out_tstrb[oc]  = out_tvalid[oc] ? head[qc][DATA_WIDTH +: STRB_WIDTH] : '0;
            out_tid[oc]    = out_tvalid[oc] ? head[qc][DATA_WIDTH+STRB_WIDTH +: ID_WIDTH] : '0;
            out_tlast[oc]  = out_tvalid[oc] && head[qc][FW-1];
            done[oc]       = out_tvalid[oc] && out_tready[oc] && head[qc][FW-1];
            if (out_tvalid[oc] && out_tready[oc]) pop[qc] = 1'b1;
        end
    end

    // Round-robin search; when locked, it starts after the owner and skips it so a
    // finishing packet hands over to the next requester without a bubble.
    always_comb begin
        int base;
        int cand;
        int qc;
        for (int oc = 0; oc < CHANNEL_NUMBER; oc++) begin
            sel[oc]     = '0;
            sel_vld[oc] = 1'b0;
            base = int'(locked[oc] ? owner[oc] : rr_ptr[oc]);
            for (int i = 1; i <= PORT_NUMBER; i++) begin
                cand = (base + i) % PORT_NUMBER;
                qc   = cand * VNET_NUMBER + oc % VNET_NUMBER;
                if (!sel_vld[oc] && !(locked[oc] && i == PORT_NUMBER) && head_vld[qc]
                    && route[qc] == PW'(oc / VNET_NUMBER)) begin
                    sel_vld[oc] = 1'b1;
                    sel[oc]     = PW'(cand);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNEL_NUMBER; c++) begin
            if (push[c]) mem[c][wr_ptr[c]] <= {in_tlast[c], in_tid[c], in_tstrb[c], in_tdata[c]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNEL_NUMBER; c++) begin
                wr_ptr[c]    <= '0;
                rd_ptr[c]    <= '0;
                count[c]     <= '0;
                route_vld[c] <= 1'b0;
                route_lat[c] <= '0;
                locked[c]    <= 1'b0;
                owner[c]     <= '0;
                rr_ptr[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNEL_NUMBER; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + AW'(1);
                count[c] <= count[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
                if (pop[c]) begin
                    if (head[c][FW-1]) begin
                        route_vld[c] <= 1'b0;
                    end else if (!route_vld[c]) begin
                        route_vld[c] <= 1'b1;
                        route_lat[c] <= route[c];
                    end
                end
                if (!locked[c]) begin
                    if (sel_vld[c]) begin
                        locked[c] <= 1'b1;
                        owner[c]  <= sel[c];
                    end
                end else if (done[c]) begin
                    rr_ptr[c] <= owner[c];
                    if (sel_vld[c]) owner[c] <= sel[c];
                    else            locked[c] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_router_multi_vnet.sv
// Bench for router_multi_vnet at node (1,1): directed scenarios plus random traffic,
// checked by a tag-based scoreboard (route, per-input order, packet contiguity, fields).
module tb_router_multi_vnet;
    localparam int DW = 32, IW = 4, P = 5, V = 2, CN = 10, MAXT = 16384;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  id;
        logic        last;
    } flit_t;

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0] in_tdata [CN];
    logic [3:0]    in_tstrb [CN];
    logic [IW-1:0] in_tid [CN];
    logic          in_tlast [CN];
    logic          in_tvalid [CN];
    logic          in_tready [CN];
    logic [DW-1:0] out_tdata [CN];
    logic [3:0]    out_tstrb [CN];
    logic [IW-1:0] out_tid [CN];
    logic          out_tlast [CN];
    logic          out_tvalid [CN];
    logic          out_tready [CN];

    router_multi_vnet #(.ROUTER_X(1), .ROUTER_Y(1)) dut (
        .clk(clk), .rst(rst),
        .in_tdata(in_tdata), .in_tstrb(in_tstrb), .in_tid(in_tid), .in_tlast(in_tlast),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tstrb(out_tstrb), .out_tid(out_tid), .out_tlast(out_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready)
    );

    always #5 clk = ~clk;

    flit_t       stim_q [CN][$];
    int          in_tags [CN][$];
    int          head_log [CN][$];
    int          exp_in [MAXT], exp_out [MAXT], fire_cyc [MAXT], out_cyc [MAXT];
    logic        exp_last [MAXT];
    logic [3:0]  exp_strb [MAXT], exp_id [MAXT];
    int          cur_src [CN], deliv [CN], acc [CN], mode [CN];
    bit          fire_pend [CN], hold_v [CN];
    logic [31:0] hold_d [CN], last_data [CN];
    int          errors = 0, checks = 0, cyc = 0, next_tag = 0;
    bit          gap = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // XY dimension-order rule for a node at (1,1); returns the physical output port.
    function automatic int xy_port(input int x, input int y);
        if (x > 1) return 2;
        if (x < 1) return 4;
        if (y > 1) return 3;
        if (y < 1) return 1;
        return 0;
    endfunction

    task automatic add_packet(input int c, input int dx, input int dy, input int len);
        flit_t f;
        logic [31:0] t;
        for (int i = 0; i < len; i++) begin
            t = next_tag;
            f.data = (i == 0) ? {t[23:0], 4'h0, 2'(dy), 2'(dx)} : {t[23:0], 8'($urandom)};
            f.strb = 4'($urandom);
            f.id   = 4'($urandom);
            f.last = (i == len - 1);
            exp_in[next_tag]   = c;
            exp_out[next_tag]  = xy_port(dx, dy) * V + c % V;
            exp_last[next_tag] = f.last;
            exp_strb[next_tag] = f.strb;
            exp_id[next_tag]   = f.id;
            stim_q[c].push_back(f);
            next_tag++;
        end
    endtask

    task automatic see_flit(input int oc);
        int tag, c, front;
        tag = int'(out_tdata[oc][31:8]);
        chk("tag_known", int'(tag < next_tag), 1);
        if (tag >= next_tag) return;
        c = exp_in[tag];
        front = (in_tags[c].size() > 0) ? in_tags[c][0] : -1;
        chk("route", oc, exp_out[tag]);
        chk("order", tag, front);
        if (in_tags[c].size() > 0) void'(in_tags[c].pop_front());
        chk("tlast", out_tlast[oc], exp_last[tag]);
        chk("tstrb", out_tstrb[oc], exp_strb[tag]);
        chk("tid", out_tid[oc], exp_id[tag]);
        if (cur_src[oc] >= 0) chk("wormhole", c, cur_src[oc]);
        else head_log[oc].push_back(c / V);
        cur_src[oc] = exp_last[tag] ? -1 : c;
        out_cyc[tag] = cyc;
        last_data[oc] = out_tdata[oc];
        deliv[oc]++;
    endtask

    // One cycle: everything decided here is what the next rising edge samples.
    task automatic step();
        flit_t f;
        @(negedge clk);
        cyc++;
        for (int oc = 0; oc < CN; oc++)
            out_tready[oc] = (mode[oc] == 1) || (mode[oc] == 2 && ($urandom % 4) != 0);
        for (int oc = 0; oc < CN; oc++) begin
            if (hold_v[oc]) begin
                chk("hold_valid", out_tvalid[oc], 1);
                chk("hold_data", out_tdata[oc], hold_d[oc]);
            end
            if (!out_tvalid[oc])
                chk("idle_zero", int'({out_tdata[oc], out_tstrb[oc], out_tid[oc], out_tlast[oc]} != '0), 0);
            hold_v[oc] = out_tvalid[oc] && !out_tready[oc];
            hold_d[oc] = out_tdata[oc];
            if (out_tvalid[oc] && out_tready[oc]) see_flit(oc);
        end
        for (int c = 0; c < CN; c++) begin
            if (fire_pend[c]) begin
                void'(stim_q[c].pop_front());
                in_tvalid[c] = 1'b0;
            end
            if (!in_tvalid[c] && stim_q[c].size() > 0 && (!gap || ($urandom % 3) != 0)) begin
                f = stim_q[c][0];
                in_tdata[c] = f.data;
                in_tstrb[c] = f.strb;
                in_tid[c]   = f.id;
                in_tlast[c] = f.last;
                in_tvalid[c] = 1'b1;
            end
            fire_pend[c] = in_tvalid[c] && in_tready[c];
            if (fire_pend[c]) begin
                acc[c]++;
                in_tags[c].push_back(int'(in_tdata[c][31:8]));
                fire_cyc[int'(in_tdata[c][31:8])] = cyc;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < CN; c++) begin
            in_tvalid[c] = 1'b0;
            fire_pend[c] = 1'b0;
            out_tready[c] = 1'b1;
        end
        #1;
        for (int c = 0; c < CN; c++) begin
            chk("rst_out_tvalid", out_tvalid[c], 0);
            chk("rst_in_tready", in_tready[c], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < CN; c++) begin
            stim_q[c].delete();
            in_tags[c].delete();
            cur_src[c] = -1;
            hold_v[c] = 1'b0;
        end
        #1;
        for (int c = 0; c < CN; c++) begin
            chk("post_rst_in_tready", in_tready[c], 1);
            chk("post_rst_out_tvalid", out_tvalid[c], 0);
        end
    endtask

    task automatic run_until(input int oc, input int target, input int budget, input string tag);
        int n = 0;
        while (deliv[oc] < target && n < budget) begin
            step();
            n++;
        end
        chk(tag, deliv[oc], target);
    endtask

    initial begin
        int t0, t1, t2, b, pending, n;
        rst = 1'b1;
        for (int c = 0; c < CN; c++) begin
            in_tdata[c] = '0; in_tstrb[c] = '0; in_tid[c] = '0; in_tlast[c] = 1'b0;
            in_tvalid[c] = 1'b0; out_tready[c] = 1'b0;
            cur_src[c] = -1; deliv[c] = 0; acc[c] = 0; mode[c] = 1;
            fire_pend[c] = 1'b0; hold_v[c] = 1'b0; last_data[c] = '0;
        end
        repeat (3) @(negedge clk);
        do_reset();

        // Single-flit local packet to (3,1): exits east vnet 0, two cycles after accept.
        add_packet(0, 3, 1, 1);
        run_until(4, 1, 20, "t1_delivered");
        chk("t1_latency", out_cyc[0] - fire_cyc[0], 2);
        chk("t1_data", last_data[4], 32'h7);

        // North v1 -> south v1 and west v1 -> east v1, concurrently.
        t0 = next_tag; add_packet(3, 1, 3, 1);
        t1 = next_tag; add_packet(9, 2, 2, 1);
        n = 0;
        while ((deliv[7] < 1 || deliv[5] < 1) && n < 20) begin step(); n++; end
        chk("t2_south_v1", deliv[7], 1);
        chk("t2_east_v1", deliv[5], 1);
        chk("t2_concurrent", out_cyc[t0], out_cyc[t1]);

        // Three 3-flit packets contend for east vnet 0.
        head_log[4].delete();
        b = deliv[4];
        t2 = next_tag; add_packet(0, 3, 1, 3);
        t0 = next_tag; add_packet(2, 3, 1, 3);
        add_packet(8, 3, 1, 3);
        run_until(4, b + 9, 40, "t3_delivered");
        chk("t3_pkts", head_log[4].size(), 3);
        if (head_log[4].size() == 3) begin
            chk("t3_first_north", head_log[4][0], 1);
            chk("t3_second_west", head_log[4][1], 4);
            chk("t3_third_local", head_log[4][2], 0);
        end
        chk("t3_no_bubble", out_cyc[t2 + 2] - out_cyc[t0], 8);

        // East vnet 0 blocked; east vnet 1 keeps flowing.
        mode[4] = 0;
        b = deliv[4];
        t0 = deliv[5];
        add_packet(0, 3, 1, 1);
        add_packet(1, 3, 1, 3);
        repeat (12) step();
        chk("t4_v1_flows", deliv[5] - t0, 3);
        chk("t4_v0_stalled", deliv[4], b);
        chk("t4_v0_valid", out_tvalid[4], 1);
        mode[4] = 1;
        run_until(4, b + 1, 10, "t4_v0_released");

        // Fill north vnet 0 FIFO towards a blocked local output.
        mode[0] = 0;
        b = deliv[0];
        t0 = acc[2];
        for (int i = 0; i < 17; i++) add_packet(2, 1, 1, 1);
        repeat (25) step();
        chk("t5_accepted", acc[2] - t0, 16);
        chk("t5_full_tready", in_tready[2], 0);
        mode[0] = 1;
        run_until(0, b + 17, 80, "t5_drained");

        // Reset mid-packet, then a fresh packet must route cleanly.
        add_packet(0, 3, 1, 4);
        repeat (2) step();
        do_reset();
        b = deliv[4];
        add_packet(0, 3, 1, 2);
        run_until(4, b + 2, 20, "t6_after_reset");
        repeat (5) step();

        // Random traffic with random backpressure and input gaps.
        gap = 1'b1;
        for (int c = 0; c < CN; c++) mode[c] = 2;
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < CN; c++)
                if (stim_q[c].size() == 0 && ($urandom % 4) == 0 && next_tag < MAXT - 8)
                    add_packet(c, int'($urandom % 4), int'($urandom % 4), 1 + int'($urandom % 4));
            step();
        end
        for (int c = 0; c < CN; c++) mode[c] = 1;
        n = 0;
        pending = 1;
        while (pending != 0 && n < 3000) begin
            step();
            n++;
            pending = 0;
            for (int c = 0; c < CN; c++) pending += in_tags[c].size() + stim_q[c].size();
        end
        chk("drain_pending", pending, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
